// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg: shared state encoding and default parameters for the PC sequencer.
package pc_sequencer_pkg;

    typedef enum logic [1:0] {
        ISSUE    = 2'd0,
        WAIT_ACK = 2'd1,
        EXEC     = 2'd2,
        HALT     = 2'd3
    } state_t;

    localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] DEF_PC_INC    = 32'd1;

endpackage

// File: rtl/pc_sequencer_pc_reg.sv
// pc_reg: 32-bit load-enabled register with asynchronous active-low reset to RST_VAL.
module pc_reg #(
    parameter logic [31:0] RST_VAL = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] d,
    output logic [31:0] q
);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            q <= RST_VAL;
        else if (load)
            q <= d;

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: multi-cycle fetch/execute sequencer owning the program counter.
// Outputs decode from state or come straight from registers, so no input reaches an output combinationally.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_VEC = DEF_RESET_VEC,
    parameter logic [31:0] PC_INC    = DEF_PC_INC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        halt_req,
    input  logic        resume,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    input  logic        ex_done,
    input  logic        redirect,
    input  logic [31:0] redirect_target,
    output logic [31:0] pc,
    output logic        halted,
    output logic [31:0] retired
);

    state_t      state, next;
    logic        halt_pend;
    logic        pc_load, instr_load;
    logic [31:0] pc_next;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            state <= ISSUE;
        else
            state <= next;

    always_comb begin
        next = state;
        case (state)
            ISSUE:    next = (halt_pend || halt_req) ? HALT : stall ? ISSUE : WAIT_ACK;
            WAIT_ACK: next = imem_ack ? EXEC : WAIT_ACK;
            EXEC:     next = ex_done ? ISSUE : EXEC;
            HALT:     next = (resume && !halt_req) ? ISSUE : HALT;
            default:  next = ISSUE;
        endcase
    end

    // A halt seen mid-instruction is remembered until the next ISSUE so it never aborts a fetch.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            halt_pend <= 1'b0;
        else if (next == HALT && state != HALT)
            halt_pend <= 1'b0;
        else if (halt_req && state != HALT)
            halt_pend <= 1'b1;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            retired <= 32'd0;
        else if (pc_load)
            retired <= retired + 32'd1;

    assign pc_load    = (state == EXEC) && ex_done;
    assign instr_load = (state == WAIT_ACK) && imem_ack;
    assign pc_next    = redirect ? redirect_target : pc + PC_INC;

    pc_reg #(.RST_VAL(RESET_VEC)) u_pc (
        .clk  (clk),
        .rst_n(rst_n),
        .load (pc_load),
        .d    (pc_next),
        .q    (pc)
    );

    pc_reg #(.RST_VAL(32'h0000_0000)) u_instr (
        .clk  (clk),
        .rst_n(rst_n),
        .load (instr_load),
        .d    (imem_rdata),
        .q    (instr)
    );

    assign imem_req    = (state == WAIT_ACK);
    assign imem_addr   = pc;
    assign instr_valid = (state == EXEC);
    assign halted      = (state == HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: table-driven directed check of the PC sequencer, plus async reset corner.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n, stall, halt_req, resume, imem_ack, ex_done, redirect;
    logic [31:0] imem_rdata, redirect_target;
    logic        imem_req, instr_valid, halted;
    logic [31:0] imem_addr, instr, pc, retired;

    int nvec = 0;
    int nbad = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .halt_req       (halt_req),
        .resume         (resume),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .ex_done        (ex_done),
        .redirect       (redirect),
        .redirect_target(redirect_target),
        .pc             (pc),
        .halted         (halted),
        .retired        (retired)
    );

    typedef struct {
        logic        s, h, r, a;
        logic [31:0] rd;
        logic        e, rr;
        logic [31:0] t;
        logic        req, iv;
        logic [31:0] ins, p;
        logic        hl;
        logic [31:0] rt;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic s, h, r, a, input logic [31:0] rd, input logic e, rr,
                       input logic [31:0] t, input logic req, iv, input logic [31:0] ins, p,
                       input logic hl, input logic [31:0] rt);
        vq.push_back('{s, h, r, a, rd, e, rr, t, req, iv, ins, p, hl, rt});
    endtask

    task automatic check(input string name, input logic req, iv, input logic [31:0] ins, p,
                         input logic hl, input logic [31:0] rt);
        nvec++;
        if (imem_req !== req || instr_valid !== iv || instr !== ins || pc !== p ||
            imem_addr !== p || halted !== hl || retired !== rt) begin
            nbad++;
            $display("FAIL %s: got req=%b addr=%h iv=%b instr=%h pc=%h halted=%b retired=%0d; want req=%b addr=%h iv=%b instr=%h pc=%h halted=%b retired=%0d",
                     name, imem_req, imem_addr, instr_valid, instr, pc, halted, retired,
                     req, p, iv, ins, p, hl, rt);
        end
    endtask

    initial begin
        rst_n = 1'b0; stall = 0; halt_req = 0; resume = 0; imem_ack = 0; ex_done = 0;
        redirect = 0; imem_rdata = 0; redirect_target = 0;

        //  s h r a  rdata          e rr target         | req iv instr          pc             hl ret
        add(0,0,0,1, 32'h111,       1,1,32'h999,          1,0, 32'h0,          32'h0,         0, 0);
        add(0,0,0,1, 32'hA0,        1,1,32'h999,          0,1, 32'hA0,         32'h0,         0, 0);
        add(0,0,0,1, 32'h222,       1,0,32'h0,            0,0, 32'hA0,         32'h1,         0, 1);
        add(0,0,0,1, 32'h0,         1,0,32'h0,            1,0, 32'hA0,         32'h1,         0, 1);
        add(0,0,0,1, 32'hA1,        1,0,32'h0,            0,1, 32'hA1,         32'h1,         0, 1);
        add(0,0,0,1, 32'h0,         1,0,32'h0,            0,0, 32'hA1,         32'h2,         0, 2);
        add(0,0,0,1, 32'h0,         1,0,32'h0,            1,0, 32'hA1,         32'h2,         0, 2);
        add(0,0,0,1, 32'hA2,        1,0,32'h0,            0,1, 32'hA2,         32'h2,         0, 2);
        add(0,0,0,1, 32'h0,         1,0,32'h0,            0,0, 32'hA2,         32'h3,         0, 3);
        add(0,0,0,1, 32'h0,         1,0,32'h0,            1,0, 32'hA2,         32'h3,         0, 3);
        add(0,0,0,1, 32'hA3,        1,0,32'h0,            0,1, 32'hA3,         32'h3,         0, 3);
        add(0,0,0,1, 32'h0,         1,1,32'h40,           0,0, 32'hA3,         32'h40,        0, 4);
        add(0,0,0,1, 32'h0,         1,0,32'h0,            1,0, 32'hA3,         32'h40,        0, 4);
        add(0,0,0,1, 32'hA4,        1,0,32'h0,            0,1, 32'hA4,         32'h40,        0, 4);
        add(0,0,0,1, 32'h0,         1,0,32'h0,            0,0, 32'hA4,         32'h41,        0, 5);
        for (int i = 0; i < 4; i++)
            add(1,0,0,1, 32'h0,     1,0,32'h0,            0,0, 32'hA4,         32'h41,        0, 5);
        add(0,0,0,1, 32'h0,         1,0,32'h0,            1,0, 32'hA4,         32'h41,        0, 5);
        add(0,0,0,1, 32'hA5,        1,0,32'h0,            0,1, 32'hA5,         32'h41,        0, 5);
        add(0,0,0,1, 32'h0,         1,0,32'h0,            0,0, 32'hA5,         32'h42,        0, 6);
        add(0,0,0,0, 32'h0,         1,0,32'h0,            1,0, 32'hA5,         32'h42,        0, 6);
        add(0,1,0,0, 32'h0,         1,0,32'h0,            1,0, 32'hA5,         32'h42,        0, 6);
        add(0,0,0,1, 32'hA6,        1,0,32'h0,            0,1, 32'hA6,         32'h42,        0, 6);
        add(0,0,0,1, 32'h0,         1,0,32'h0,            0,0, 32'hA6,         32'h43,        0, 7);
        add(0,0,0,0, 32'h0,         0,0,32'h0,            0,0, 32'hA6,         32'h43,        1, 7);
        add(0,0,0,0, 32'h0,         0,0,32'h0,            0,0, 32'hA6,         32'h43,        1, 7);
        add(0,1,1,0, 32'h0,         0,0,32'h0,            0,0, 32'hA6,         32'h43,        1, 7);
        add(0,0,1,0, 32'h0,         0,0,32'h0,            0,0, 32'hA6,         32'h43,        0, 7);
        add(0,0,0,0, 32'h0,         0,0,32'h0,            1,0, 32'hA6,         32'h43,        0, 7);
        for (int i = 0; i < 4; i++)
            add(1,0,0,0, 32'h0,     1,1,32'h999,          1,0, 32'hA6,         32'h43,        0, 7);
        add(0,0,0,1, 32'hDEADBEEF,  1,0,32'h0,            0,1, 32'hDEADBEEF,   32'h43,        0, 7);
        add(0,0,0,1, 32'h555,       0,0,32'h0,            0,1, 32'hDEADBEEF,   32'h43,        0, 7);
        add(0,0,0,1, 32'h0,         1,0,32'h0,            0,0, 32'hDEADBEEF,   32'h44,        0, 8);
        add(0,0,0,1, 32'h0,         1,0,32'h0,            1,0, 32'hDEADBEEF,   32'h44,        0, 8);
        add(0,0,0,1, 32'hA7,        1,0,32'h0,            0,1, 32'hA7,         32'h44,        0, 8);
        add(0,0,0,1, 32'h0,         1,1,32'hFFFFFFFF,     0,0, 32'hA7,         32'hFFFFFFFF,  0, 9);
        add(0,0,0,1, 32'h0,         1,0,32'h0,            1,0, 32'hA7,         32'hFFFFFFFF,  0, 9);
        add(0,0,0,1, 32'hA8,        1,0,32'h0,            0,1, 32'hA8,         32'hFFFFFFFF,  0, 9);
        add(0,0,0,1, 32'h0,         1,0,32'h0,            0,0, 32'hA8,         32'h0,         0, 10);
        add(0,0,0,1, 32'h0,         1,0,32'h0,            1,0, 32'hA8,         32'h0,         0, 10);
        add(0,0,0,1, 32'hA9,        1,0,32'h0,            0,1, 32'hA9,         32'h0,         0, 10);
        add(0,0,0,1, 32'h0,         1,1,32'h10,           0,0, 32'hA9,         32'h10,        0, 11);
        add(0,0,0,0, 32'h0,         1,0,32'h0,            1,0, 32'hA9,         32'h10,        0, 11);

        repeat (2) @(posedge clk);
        #1 check("reset_state", 0, 0, 32'h0, 32'h0, 0, 32'd0);
        rst_n = 1'b1;

        foreach (vq[i]) begin
            stall = vq[i].s; halt_req = vq[i].h; resume = vq[i].r; imem_ack = vq[i].a;
            imem_rdata = vq[i].rd; ex_done = vq[i].e; redirect = vq[i].rr;
            redirect_target = vq[i].t;
            @(posedge clk);
            #1 check($sformatf("vec%0d", i), vq[i].req, vq[i].iv, vq[i].ins, vq[i].p,
                     vq[i].hl, vq[i].rt);
        end

        // Async reset lands mid-handshake, between clock edges.
        stall = 0; halt_req = 0; resume = 0; imem_ack = 0; ex_done = 0; redirect = 0;
        #2 rst_n = 1'b0;
        #1 check("async_reset_mid_wait", 0, 0, 32'h0, 32'h0, 0, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        begin
            int n = 0;
            while (!imem_req && n < 4) begin
                @(posedge clk);
                #1 n++;
            end
            check("refetch_after_reset", 1, 0, 32'h0, 32'h0, 0, 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
